counter_seq_checker: RTL and testbench

//  Synthesizable on-fabric monitor for a free-running modulo-2^WIDTH counter bus
//  (e.g. a design's led[3:0] output looped back to inputs). Samples the bus on

---
 rtl/counter_seq_checker_if.sv | 42 ++++
 rtl/counter_seq_checker.sv | 153 +++++++++++++++
 tb/tb_counter_seq_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_checker_if.sv
// ----------------------------------------------------------------------------
// counter_seq_checker_if
// Bundles the observed counter bus, its control strobes and the checker's
// status outputs.
//   master : drives en, clr, cnt_in; reads the status outputs
//   slave  : the checker itself
// Parameters must match those of the counter_seq_checker instance using it.
// The fail signal exists only when COUNTER_SEQ_CHECKER_STICKY_EN is defined.
// ----------------------------------------------------------------------------
interface counter_seq_checker_if #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
);
  logic              en;
  logic              clr;
  logic [WIDTH-1:0]  cnt_in;
  logic              locked;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  bad_val;
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
  logic              fail;
`endif

  modport master (
    output en, clr, cnt_in,
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    input  fail,
`endif
    input  locked, err, err_cnt, wrap_cnt, bad_val
  );

  modport slave (
    input  en, clr, cnt_in,
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
    output fail,
`endif
    output locked, err, err_cnt, wrap_cnt, bad_val
  );
endinterface

// File: rtl/counter_seq_checker.sv
// ----------------------------------------------------------------------------
// counter_seq_checker
// On-fabric monitor for a free-running modulo-2^WIDTH counter bus. Locks onto
// the increment sequence after LOCK_COUNT consecutive good increments, then
// flags, counts and records deviations and counts observed wraps.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : counter_seq_checker_if.slave
//            en       sample enable (low forces a fresh reference later)
//            clr      synchronous clear of counters and state, beats en
//            cnt_in   observed counter value, already synchronous to clk
//            locked   high while in LOCKED
//            err      one-cycle pulse per mismatch seen while LOCKED
//            err_cnt  saturating count of mismatches while LOCKED
//            wrap_cnt saturating count of all-ones->0 steps while LOCKED
//            bad_val  cnt_in value that caused the most recent err
//            fail     (sticky build only) set on first err until rst_n/clr
//
// Build option: define COUNTER_SEQ_CHECKER_STICKY_EN to add the sticky fail
// output; while it is set the checker never relocks and err_cnt is frozen.
// ----------------------------------------------------------------------------
module counter_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  counter_seq_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  bad_q;
  logic [MW-1:0]     match_q;
  logic              err_q;
  logic [ERR_W-1:0]  ecnt_q;
  logic [WRAP_W-1:0] wcnt_q;
  logic              fail_q;

  logic [WIDTH-1:0]  expected;
  logic [MW-1:0]     match_nxt;
  logic              hit;
  logic              wrap_obs;
  logic              relock_ok;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Modulo-2^WIDTH increment: all-ones followed by zero is a legal step.
  assign expected  = prev_q + 1'b1;
  assign match_nxt = match_q + 1'b1;
  assign hit       = (bus.cnt_in == expected);
  assign wrap_obs  = (&prev_q) && (bus.cnt_in == '0);

`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
  assign relock_ok = !fail_q;
  assign bus.fail  = fail_q;
`else
  assign relock_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      prev_q  <= '0;
      match_q <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      wcnt_q  <= '0;
      bad_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.clr) begin
        state_q <= SEARCH;
        match_q <= '0;
        ecnt_q  <= '0;
        wcnt_q  <= '0;
        bad_q   <= '0;
        fail_q  <= 1'b0;
      end else if (!bus.en) begin
        // Re-enable always starts from a fresh reference sample.
        state_q <= SEARCH;
      end else begin
        case (state_q)
          SEARCH: begin
            prev_q  <= bus.cnt_in;
            match_q <= '0;
            state_q <= ACQUIRE;
          end
          ACQUIRE: begin
            prev_q <= bus.cnt_in;
            if (hit) begin
              if (match_nxt == LOCK_V) begin
                // A failed sticky checker parks here with the count held.
                if (relock_ok) begin
                  match_q <= match_nxt;
                  state_q <= LOCKED;
                end
              end else begin
                match_q <= match_nxt;
              end
            end else begin
              match_q <= '0;
            end
          end
          LOCKED: begin
            // Resync to whatever arrived so a single glitch costs one err.
            prev_q <= bus.cnt_in;
            if (hit) begin
              if (wrap_obs) wcnt_q <= sat_inc_wrap(wcnt_q);
            end else begin
              err_q   <= 1'b1;
              if (!fail_q) ecnt_q <= sat_inc_err(ecnt_q);
              bad_q   <= bus.cnt_in;
              match_q <= '0;
              state_q <= ACQUIRE;
`ifdef COUNTER_SEQ_CHECKER_STICKY_EN
              fail_q  <= 1'b1;
`endif
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked   = (state_q == LOCKED);
  assign bus.err      = err_q;
  assign bus.err_cnt  = ecnt_q;
  assign bus.wrap_cnt = wcnt_q;
  assign bus.bad_val  = bad_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
module tb_counter_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_s;
  logic       clr_s;
  logic [3:0] cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_seq_checker_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) ifc0 ();
  counter_seq_checker_if #(.WIDTH(4), .ERR_W(2), .WRAP_W(8)) ifc1 ();

  assign ifc0.en = en_s;  assign ifc0.clr = clr_s;  assign ifc0.cnt_in = cnt_s;
  assign ifc1.en = en_s;  assign ifc1.clr = clr_s;  assign ifc1.cnt_in = cnt_s;

  counter_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(8), .WRAP_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0)
  );
  counter_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(2), .WRAP_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1)
  );

  // m bits: 0 locked, 1 err, 2 err_cnt, 3 wrap_cnt, 4 bad_val,
  //         5 err_cnt of the ERR_W=2 instance, 6 err of that instance
  typedef struct {
    string      name;
    bit [6:0]   m;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [7:0] wc;
    logic [3:0] bv;
    logic [1:0] ec2;
    logic       er2;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t nx(input string n);
    exp_t x;
    x.name = n; x.m = '0; x.lk = 1'b0; x.er = 1'b0; x.ec = '0; x.wc = '0;
    x.bv = '0; x.ec2 = '0; x.er2 = 1'b0;
    return x;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, req);
    end
  endtask

  // One sample per call: inputs applied at negedge, expectation for the
  // outputs right after the next rising edge goes to the scoreboard.
  task automatic step(input logic e, input logic c, input logic [3:0] v, input exp_t x);
    @(negedge clk);
    en_s = e; clr_s = c; cnt_s = v;
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        if (x.m[0]) chk({x.name, ".locked"},   32'(ifc0.locked),   32'(x.lk));
        if (x.m[1]) chk({x.name, ".err"},      32'(ifc0.err),      32'(x.er));
        if (x.m[2]) chk({x.name, ".err_cnt"},  32'(ifc0.err_cnt),  32'(x.ec));
        if (x.m[3]) chk({x.name, ".wrap_cnt"}, 32'(ifc0.wrap_cnt), 32'(x.wc));
        if (x.m[4]) chk({x.name, ".bad_val"},  32'(ifc0.bad_val),  32'(x.bv));
        if (x.m[5]) chk({x.name, ".err_cnt2"}, 32'(ifc1.err_cnt),  32'(x.ec2));
        if (x.m[6]) chk({x.name, ".err2"},     32'(ifc1.err),      32'(x.er2));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_zero(input string n);
    chk({n, ".locked"},   32'(ifc0.locked),   0);
    chk({n, ".err"},      32'(ifc0.err),      0);
    chk({n, ".err_cnt"},  32'(ifc0.err_cnt),  0);
    chk({n, ".wrap_cnt"}, 32'(ifc0.wrap_cnt), 0);
    chk({n, ".bad_val"},  32'(ifc0.bad_val),  0);
    chk({n, ".err_cnt2"}, 32'(ifc1.err_cnt),  0);
  endtask

  initial begin : stim
    exp_t x;
    int   b;
    rst_n = 1'b0; en_s = 1'b0; clr_s = 1'b0; cnt_s = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Clean count 1..63 mod 16: locked after the 4th sample, three wraps.
    for (int i = 1; i <= 63; i++) begin
      x = nx("count"); x.m = 7'b0001111;
      x.lk = (i >= 4); x.wc = 8'(i / 16);
      step(1'b1, 1'b0, 4'(i % 16), x);
    end

    // Continue 0..6 (fourth wrap), then skip 7.
    for (int v = 0; v <= 6; v++) begin
      x = nx("pre_skip"); x.m = 7'b0001011; x.lk = 1'b1; x.wc = 8'd4;
      step(1'b1, 1'b0, 4'(v), x);
    end
    x = nx("skip"); x.m = 7'b0010111; x.er = 1'b1; x.ec = 8'd1; x.bv = 4'd8;
    step(1'b1, 1'b0, 4'd8, x);
    x = nx("relock9");  x.m = 7'b0000011; step(1'b1, 1'b0, 4'd9, x);
    x = nx("relock10"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd10, x);
    x = nx("relock11"); x.m = 7'b0000111; x.lk = 1'b1; x.ec = 8'd1;
    step(1'b1, 1'b0, 4'd11, x);

    // Stuck bus at 7: exactly one err, never relocks.
    x = nx("stuck_first"); x.m = 7'b0010111; x.er = 1'b1; x.ec = 8'd2; x.bv = 4'd7;
    step(1'b1, 1'b0, 4'd7, x);
    for (int i = 0; i < 9; i++) begin
      x = nx("stuck"); x.m = 7'b0000111; x.ec = 8'd2;
      step(1'b1, 1'b0, 4'd7, x);
    end
    x = nx("relock8");   x.m = 7'b0000001; step(1'b1, 1'b0, 4'd8, x);
    x = nx("relock9b");  x.m = 7'b0000001; step(1'b1, 1'b0, 4'd9, x);
    x = nx("relock10b"); x.m = 7'b0000001; x.lk = 1'b1; step(1'b1, 1'b0, 4'd10, x);

    // clr together with en while locked with err_cnt=2, wrap_cnt=4.
    x = nx("clr"); x.m = 7'b0011111; step(1'b1, 1'b1, 4'd11, x);
    x = nx("post_clr12"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd12, x);
    x = nx("post_clr13"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd13, x);
    x = nx("post_clr14"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd14, x);
    x = nx("post_clr15"); x.m = 7'b0000001; x.lk = 1'b1; step(1'b1, 1'b0, 4'd15, x);
    x = nx("post_clr_wrap"); x.m = 7'b0001001; x.lk = 1'b1; x.wc = 8'd1;
    step(1'b1, 1'b0, 4'd0, x);

    // en low drops lock but holds counters; re-enable on a jump gives no err.
    x = nx("en_low"); x.m = 7'b0001111; x.wc = 8'd1; step(1'b0, 1'b0, 4'd5, x);
    x = nx("reenable"); x.m = 7'b0000111; step(1'b1, 1'b0, 4'd9, x);
    x = nx("re10"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd10, x);
    x = nx("re11"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'd11, x);
    x = nx("re12"); x.m = 7'b0000001; x.lk = 1'b1; step(1'b1, 1'b0, 4'd12, x);
    x = nx("err14"); x.m = 7'b0010111; x.er = 1'b1; x.ec = 8'd1; x.bv = 4'd14;
    step(1'b1, 1'b0, 4'd14, x);

    // Async reset while err is high clears everything at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    x = nx("after_rst"); x.m = 7'b0000111; step(1'b1, 1'b0, 4'd3, x);

    // Five isolated mismatches with relock between; ERR_W=2 copy saturates.
    x = nx("sat_clr"); x.m = 7'b0100100; step(1'b1, 1'b1, 4'd0, x);
    b = 0;
    x = nx("sat_search"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'(b), x);
    for (int k = 1; k <= 5; k++) begin
      x = nx("sat_a"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'((b + 1) % 16), x);
      x = nx("sat_b"); x.m = 7'b0000001; step(1'b1, 1'b0, 4'((b + 2) % 16), x);
      x = nx("sat_lock"); x.m = 7'b0000001; x.lk = 1'b1;
      step(1'b1, 1'b0, 4'((b + 3) % 16), x);
      x = nx("sat_err"); x.m = 7'b1110111;
      x.er = 1'b1; x.er2 = 1'b1; x.ec = 8'(k); x.ec2 = 2'((k > 3) ? 3 : k);
      x.bv = 4'((b + 5) % 16);
      step(1'b1, 1'b0, 4'((b + 5) % 16), x);
      b = (b + 5) % 16;
    end

    @(negedge clk);
    en_s = 1'b0;
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
